// File: rtl/rev_addr_seq_pkg.sv
// Shared definitions for the bit-reversal address sequencer: default geometry
// and the controller state encoding.
package rev_addr_seq_pkg;

    localparam int SEQ_DEPTH = 240;
    localparam int SEQ_AW    = 8;
    localparam int SEQ_DW    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } seq_state_t;

    function automatic logic len_legal(input int l, input int depth);
        return (l >= 1) && (l <= depth);
    endfunction

endpackage

// File: rtl/rev_addr_seq_if.sv
// Control, ROM-read and output-stream signals of the sequencer, bundled for
// the block boundary.
interface rev_addr_seq_if #(
    parameter int AW = rev_addr_seq_pkg::SEQ_AW,
    parameter int DW = rev_addr_seq_pkg::SEQ_DW
);
    logic          start;
    logic [AW-1:0] len;
    logic          busy;
    logic          done;
    logic          err;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          out_last;

    modport slave (
        input  start, len, rom_dout, out_ready,
        output busy, done, err, rom_en, rom_addr,
               out_valid, out_data, out_idx, out_last
    );

    modport master (
        output start, len, rom_dout, out_ready,
        input  busy, done, err, rom_en, rom_addr,
               out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/rev_skid_fifo.sv
// Two-entry fall-through FIFO: a write into an empty FIFO is visible at the
// head in the same cycle, so ROM data reaches the output without extra latency.
module rev_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count
);
    logic [1:0][W-1:0] mem;
    logic              wp, rp;
    logic [1:0]        cnt;
    logic              empty, push, drop;

    assign empty    = (cnt == 2'd0);
    assign rd_valid = !empty || wr_en;
    // Head reads as zero when nothing is valid so idle outputs stay clean.
    assign rd_data  = !rd_valid ? '0 : (empty ? wr_data : mem[rp]);
    assign push     = wr_en && !(empty && rd_en);
    assign drop     = rd_en && !empty;
    assign count    = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (push) wp <= ~wp;
            if (drop) rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, drop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= wr_data;
    end

endmodule

// File: rtl/rev_addr_seq.sv
// Walks an external reorder-table ROM from address 0 to len-1 and streams the
// entries out with their index, under ready/valid backpressure.
module rev_addr_seq
    import rev_addr_seq_pkg::*;
#(
    parameter int DEPTH = SEQ_DEPTH,
    parameter int AW    = SEQ_AW,
    parameter int DW    = SEQ_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    rev_addr_seq_if.slave bus
);
    localparam int FW = 1 + AW + DW;

    seq_state_t    state;
    logic [AW-1:0] len_q, addr_q, idx_q;
    logic          inflight_q, err_pend, busy_q, done_q, err_q;
    logic          issue, pop, fifo_valid;
    logic [1:0]    occ;
    logic [FW-1:0] wr_word, head;

    assign pop     = fifo_valid & bus.out_ready;
    assign wr_word = {(idx_q == len_q - AW'(1)), idx_q, bus.rom_dout};

    // Buffered + in-flight words, net of this cycle's pop, must leave room
    // for the word this read will deliver next cycle.
    always_comb begin
        issue = 1'b0;
        if (state == RUN)
            issue = (({1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            inflight_q <= 1'b0;
            err_pend   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            inflight_q <= issue;
            if (issue) idx_q <= addr_q;
            case (state)
                IDLE: if (bus.start) begin
                    len_q  <= bus.len;
                    addr_q <= '0;
                    busy_q <= 1'b1;
                    if (len_legal(int'(bus.len), DEPTH)) begin
                        state <= RUN;
                    end else begin
                        // Illegal length idles one DRAIN cycle so done/err
                        // land two cycles after the start, like a short run.
                        err_pend <= 1'b1;
                        state    <= DRAIN;
                    end
                end
                RUN: if (issue) begin
                    addr_q <= addr_q + AW'(1);
                    if (addr_q == len_q - AW'(1)) state <= DRAIN;
                end
                DRAIN: begin
                    if (err_pend) begin
                        err_pend <= 1'b0;
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        state    <= FIN;
                    end else if (pop && head[FW-1]) begin
                        done_q <= 1'b1;
                        state  <= FIN;
                    end
                end
                FIN: begin
                    busy_q <= 1'b0;
                    addr_q <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    rev_skid_fifo #(.W(FW)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (inflight_q),
        .wr_data  (wr_word),
        .rd_en    (pop),
        .rd_valid (fifo_valid),
        .rd_data  (head),
        .count    (occ)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rom_en    = issue;
    assign bus.rom_addr  = addr_q;
    assign bus.out_valid = fifo_valid;
    assign bus.out_last  = head[FW-1];
    assign bus.out_idx   = head[DW +: AW];
    assign bus.out_data  = head[DW-1:0];

endmodule

// File: tb/tb_rev_addr_seq.sv
// Randomised bench for rev_addr_seq: a behavioural ROM plus an expected-word
// list derived directly from the table contents.
module tb_rev_addr_seq;
    import rev_addr_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] rom [0:255];

    rev_addr_seq_if #(.AW(8), .DW(9)) bus ();

    rev_addr_seq #(.DEPTH(240), .AW(8), .DW(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data valid the cycle after the enable.
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_dout <= rom[bus.rom_addr];
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_done"},  bus.done, 0);
        chk({tag, "_err"},   bus.err, 0);
        chk({tag, "_romen"}, bus.rom_en, 0);
        chk({tag, "_raddr"}, bus.rom_addr, 0);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_last"},  bus.out_last, 0);
        chk({tag, "_data"},  bus.out_data, 0);
        chk({tag, "_idx"},   bus.out_idx, 0);
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2 == 0);
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    function automatic int exp_word(input int k);
        return (k >= 0 && k < 256) ? int'(rom[k]) : 0;
    endfunction

    // One legal sequence. Optional extras: a stray start at extra_cyc, a reset
    // after rst_word pops, or a start driven into the FIN cycle (ready held high).
    task automatic run_seq(input int L, input int mode, input int extra_cyc,
                           input int rst_word, input bit fin_start);
        int rd_cnt, pops, last_pop, budget;
        bit got_done, stall;
        int pd, pix, pl;
        rd_cnt = 0; pops = 0; last_pop = -1; got_done = 0; stall = 0;
        pd = 0; pix = 0; pl = 0;
        budget = 4 * L + 40;
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.len       = 8'(L);
        bus.out_ready = ready_for(mode, 0);
        @(negedge clk);
        chk("busy_pre", bus.busy, 0);
        for (int cyc = 1; cyc <= budget && !got_done; cyc++) begin
            @(posedge clk); #1;
            if (rst_word >= 0 && pops == rst_word) begin
                bus.start = 1'b0;
                rst_n = 1'b0;
                #1;
                chk_quiet("midrst");
                @(negedge clk);
                chk("midrst_nodone", bus.done, 0);
                rst_n = 1'b1;
                return;
            end
            bus.start = (cyc == extra_cyc) || (fin_start && cyc == L + 2);
            bus.len   = (cyc == extra_cyc) ? 8'd3 :
                        ((fin_start && cyc == L + 2) ? 8'd4 : 8'(L));
            bus.out_ready = ready_for(mode, cyc);
            @(negedge clk);
            if (cyc == 1) begin
                chk("first_rd", bus.rom_en, 1);
                chk("early_valid", bus.out_valid, 0);
            end
            if (cyc == 2) chk("first_valid", bus.out_valid, 1);
            if (stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, pd);
                chk("stall_idx", bus.out_idx, pix);
                chk("stall_last", bus.out_last, pl);
            end
            if (bus.rom_en) begin
                chk("rd_addr", bus.rom_addr, rd_cnt);
                chk("rd_bound", int'(rd_cnt < L), 1);
                rd_cnt++;
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("data", bus.out_data, exp_word(pops));
                chk("idx", bus.out_idx, pops);
                chk("last", bus.out_last, int'(pops == L - 1));
                pops++;
                last_pop = cyc;
            end
            chk("outstanding", int'((rd_cnt - pops) <= 2), 1);
            stall = bus.out_valid && !bus.out_ready;
            pd = bus.out_data; pix = bus.out_idx; pl = bus.out_last;
            if (bus.done) begin
                got_done = 1'b1;
                chk("done_cyc", cyc, last_pop + 1);
                chk("done_err", bus.err, 0);
                chk("words", pops, L);
                chk("reads", rd_cnt, L);
                if (mode == 0) chk("thruput", last_pop, L + 1);
            end else begin
                chk("busy_run", bus.busy, 1);
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
    endtask

    // Illegal length: nothing read, nothing emitted, done+err two cycles on.
    task automatic run_bad(input int L);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.len       = 8'(L);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bad_busy_pre", bus.busy, 0);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
            chk("bad_romen", bus.rom_en, 0);
            chk("bad_valid", bus.out_valid, 0);
            chk("bad_busy", bus.busy, int'(cyc <= 2));
            chk("bad_done", bus.done, int'(cyc == 2));
            chk("bad_err", bus.err, int'(cyc == 2));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            rom[i] = (i < 239) ? 9'(i + 1 + i / 15) : ((i == 239) ? 9'h1df : 9'h000);
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.len       = 8'd0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("por");
        @(negedge clk);
        rst_n = 1'b1;

        run_seq(240, 0, -1, -1, 1'b0);
        run_seq(16, 1, -1, -1, 1'b0);
        run_bad(0);
        run_bad(241);
        run_seq(8, 0, 4, -1, 1'b0);
        run_seq(20, 0, -1, 5, 1'b0);
        run_seq(2, 0, -1, -1, 1'b0);
        run_seq(5, 0, -1, -1, 1'b1);
        run_seq(3, 2, -1, -1, 1'b0);
        run_seq(1, 1, -1, -1, 1'b0);
        for (int r = 0; r < 6; r++)
            run_seq(int'($urandom_range(1, 240)), int'($urandom_range(0, 2)), -1, -1, 1'b0);

        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
